// File: rtl/io_pkg.sv
// Shared definitions for the board I/O peripherals (IN switch reader and
// 7-segment output block).
package io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } input_state_t;

  localparam int DATA_WIDTH              = 32;
  localparam int SW_WIDTH_DEFAULT        = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // 7-segment display: four digits, segments ordered gfedcba, active-low.
  localparam int         SEG_DIGITS = 4;
  localparam int         SEG_WIDTH  = 7;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_MINUS  = 7'h3F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/input_mod_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, consecutive-mismatch debounce
// counter, and registered one-cycle press (1->0) / release (0->1) pulses.
module debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q;
  logic             release_q;

  // A flip needs DEBOUNCE_CYCLES+1 consecutive mismatching samples; any match restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q       <= 1'b1;
      sync_q       <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      meta_q       <= btn_n_i;
      sync_q       <= meta_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_prev_q & ~level_q;
      release_q    <= ~level_prev_q & level_q;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/input_mod.sv
// IN-instruction input peripheral: stalls the core until one debounced
// press/release of the confirm button, capturing the slide switches on press.
module input_mod
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = SW_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  confirm_n,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  stall,
  output logic                  valid
);

  logic [SW_WIDTH-1:0]   sw_meta_q;
  logic [SW_WIDTH-1:0]   sw_sync_q;
  logic                  press;
  logic                  release_p;
  input_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm (
    .clk       (clk),
    .reset     (reset),
    .btn_n_i   (confirm_n),
    .press_o   (press),
    .release_o (release_p)
  );

  // While waiting for the press the stall follows read, so a squashed IN
  // releases the pipeline in the same cycle it drops read.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    stall   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = read;
        if (read) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        stall = read;
        if (!read) begin
          state_d = IDLE;
        end else if (press) begin
          out_d   = DATA_WIDTH'(sw_sync_q);
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        stall = 1'b1;
        if (release_p) begin
          state_d = DONE;
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule
